rs232_rx_buffer: RTL and testbench

- RS232 receive path: samples the serial line `iRX` (8N1, LSB first) and deposits each good byte into an 8-entry buffer. The host reads the buffer by address.
- Counterpart of the TX/write-buffer path in the `main` RS232 top. It produces the `rx_addr` write pointer and serves `oData` at `read_addr`.
- Tracks occupancy through a host acknowledge, and flags framing and overrun errors.

---
 rtl/rs232_pkg.sv | 14 +
 rtl/rs232_rx_buffer_if.sv | 33 +++
 rtl/rs232_rx_sync.sv | 30 +++
 rtl/rs232_rx_buffer.sv | 148 ++++++++++++++
 tb/tb_rs232_rx_buffer.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/rs232_pkg.sv
// Shared RS232 definitions: receiver FSM states, default bit timing and buffer depth.
// The PARITY state is used only when RS232_RX_PARITY_EN is defined.
package rs232_pkg;
    localparam int DEF_CLKS_PER_BIT = 434;  // 50 MHz / 115200 baud
    localparam int RX_DEPTH_LOG2    = 3;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;
endpackage

// File: rtl/rs232_rx_buffer_if.sv
// Host-side bus of the RS232 receive buffer: read port, write pointer, occupancy and status pulses.
// oParityErr exists only when RS232_RX_PARITY_EN is defined.
interface rs232_rx_buffer_if import rs232_pkg::*; #(
    parameter int DEPTH_LOG2 = RX_DEPTH_LOG2
) ();
    logic [DEPTH_LOG2-1:0] read_addr;
    logic [7:0]            oData;
    logic [DEPTH_LOG2-1:0] rx_addr;
    logic                  iRxAck;
    logic [DEPTH_LOG2:0]   oRxCount;
    logic                  oRxValid;
    logic                  oFrameErr;
    logic                  oOverrun;
`ifdef RS232_RX_PARITY_EN
    logic                  oParityErr;
`endif

    modport master (
        output read_addr, iRxAck,
        input  oData, rx_addr, oRxCount, oRxValid, oFrameErr, oOverrun
`ifdef RS232_RX_PARITY_EN
        , input oParityErr
`endif
    );

    modport slave (
        input  read_addr, iRxAck,
        output oData, rx_addr, oRxCount, oRxValid, oFrameErr, oOverrun
`ifdef RS232_RX_PARITY_EN
        , output oParityErr
`endif
    );
endinterface

// File: rtl/rs232_rx_sync.sv
// Two-flop synchronizer for an asynchronous input, with falling-edge detect on the synced value.
// Flops reset to 1 so an idle-high line shows no edge coming out of reset.
module rs232_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o,
    output logic fall_o
);
    logic [1:0] sync_q, sync_d;
    logic       prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[0], async_i};
        prev_d = sync_q[1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync_o = sync_q[1];
    assign fall_o = prev_q & ~sync_q[1];
endmodule

// File: rtl/rs232_rx_buffer.sv
// RS232 receiver (8N1, or 8E1 with RS232_RX_PARITY_EN) feeding an addressable 2**DEPTH_LOG2-entry buffer
// with occupancy tracking via host ack, and framing/overrun (and parity) error pulses.
module rs232_rx_buffer import rs232_pkg::*; #(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DEPTH_LOG2   = RX_DEPTH_LOG2
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iRX,
    rs232_rx_buffer_if.slave  bus
);
    localparam int CW    = $clog2(CLKS_PER_BIT);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [CW-1:0]         HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]         FULL_BIT = CW'(CLKS_PER_BIT - 1);
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    rx_state_t             state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [2:0]            idx_q, idx_d;
    logic [7:0]            shift_q, shift_d;
    logic [DEPTH_LOG2-1:0] addr_q, addr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic [7:0]            data_q, data_d;
    logic [7:0]            mem [DEPTH];

    logic rxs, rx_fall, expire, stop_hit, full, par_ok;
    logic frame_err, good, wr_en, overrun, ack_eff;

    rs232_rx_sync u_sync (
        .clk     (iClk),
        .rst_n   (iRst),
        .async_i (iRX),
        .sync_o  (rxs),
        .fall_o  (rx_fall)
    );

`ifdef RS232_RX_PARITY_EN
    logic par_q, par_d;
    assign par_ok         = (par_q == ^shift_q);
    assign bus.oParityErr = stop_hit && rxs && !par_ok;
`else
    assign par_ok = 1'b1;
`endif

    assign expire    = (cnt_q == '0);
    assign stop_hit  = (state_q == STOP) && expire;
    assign full      = (count_q == CNT_FULL);
    // A framing error masks any parity result; only one error pulse per frame.
    assign frame_err = stop_hit && !rxs;
    assign good      = stop_hit && rxs && par_ok;
    assign wr_en     = good && !full;
    assign overrun   = good && full;
    assign ack_eff   = bus.iRxAck && (count_q != '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = expire ? cnt_q : cnt_q - 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
`ifdef RS232_RX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: if (rx_fall) begin
                cnt_d   = HALF_BIT;
                state_d = START;
            end
            START: if (expire) begin
                if (!rxs) begin
                    cnt_d   = FULL_BIT;
                    idx_d   = 3'd0;
                    state_d = DATA;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: if (expire) begin
                shift_d[idx_q] = rxs;
                cnt_d          = FULL_BIT;
                if (idx_q == 3'd7) begin
`ifdef RS232_RX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
`ifdef RS232_RX_PARITY_EN
            PARITY: if (expire) begin
                par_d   = rxs;
                cnt_d   = FULL_BIT;
                state_d = STOP;
            end
`endif
            // Leave mid-stop-bit so a back-to-back start edge is not missed.
            STOP: if (expire) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        addr_d = wr_en ? addr_q + 1'b1 : addr_q;
        case ({wr_en, ack_eff})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        data_d = mem[bus.read_addr];
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            addr_q  <= '0;
            count_q <= '0;
            data_q  <= '0;
`ifdef RS232_RX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            data_q  <= data_d;
`ifdef RS232_RX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_ff @(posedge iClk) begin
        if (wr_en) mem[addr_q] <= shift_q;
    end

    assign bus.oData     = data_q;
    assign bus.rx_addr   = addr_q;
    assign bus.oRxCount  = count_q;
    assign bus.oRxValid  = wr_en;
    assign bus.oFrameErr = frame_err;
    assign bus.oOverrun  = overrun;
endmodule

// File: tb/tb_rs232_rx_buffer.sv
// Bench for rs232_rx_buffer: directed test-plan steps plus random frames against a frame-level model.
// Sends 8E1 frames with correct parity when RS232_RX_PARITY_EN is defined.
module tb_rs232_rx_buffer;
    import rs232_pkg::*;

    localparam int CPB = 8;

    logic iClk = 1'b0;
    logic iRst = 1'b0;
    logic iRX  = 1'b1;

    rs232_rx_buffer_if #(.DEPTH_LOG2(3)) bus ();

    rs232_rx_buffer #(.CLKS_PER_BIT(CPB), .DEPTH_LOG2(3)) dut (
        .iClk (iClk),
        .iRst (iRst),
        .iRX  (iRX),
        .bus  (bus)
    );

    always #5 iClk = ~iClk;

    int n_cmp = 0, n_fail = 0;
    int n_valid = 0, n_ferr = 0, n_ovr = 0;
    int exp_valid = 0, exp_ferr = 0, exp_ovr = 0;
    logic [7:0] mem_m [8];
    bit         written [8];
    int wp = 0, cnt = 0;

    always @(negedge iClk) begin
        if (bus.oRxValid)  n_valid <= n_valid + 1;
        if (bus.oFrameErr) n_ferr  <= n_ferr + 1;
        if (bus.oOverrun)  n_ovr   <= n_ovr + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge iClk);
    endtask

    task automatic check_state(input string tag);
        check({tag, " valid"},   32'(n_valid), 32'(exp_valid));
        check({tag, " ferr"},    32'(n_ferr),  32'(exp_ferr));
        check({tag, " overrun"}, 32'(n_ovr),   32'(exp_ovr));
        check({tag, " rx_addr"}, 32'(bus.rx_addr),  32'(wp));
        check({tag, " count"},   32'(bus.oRxCount), 32'(cnt));
    endtask

    // One bit period; optionally raise iRxAck in the cycle oRxValid is seen.
    task automatic drive_bit(input logic v, input bit ack_w, inout bit acked);
        repeat (CPB) begin
            @(negedge iClk);
            iRX = v;
            bus.iRxAck = 1'b0;
            if (ack_w && !acked && bus.oRxValid) begin
                bus.iRxAck = 1'b1;
                acked = 1'b1;
            end
        end
    endtask

    task automatic send(input logic [7:0] b, input logic stop, input bit ack_w, input string tag);
        bit acked = 1'b0;
        int pre = cnt;
        drive_bit(1'b0, ack_w, acked);
        for (int i = 0; i < 8; i++) drive_bit(b[i], ack_w, acked);
`ifdef RS232_RX_PARITY_EN
        drive_bit(^b, ack_w, acked);
`endif
        drive_bit(stop, ack_w, acked);
        @(negedge iClk);
        iRX = 1'b1;
        bus.iRxAck = 1'b0;
        tick(2);
        if (!stop) exp_ferr++;
        else if (cnt == 8) exp_ovr++;
        else begin
            mem_m[wp] = b;
            written[wp] = 1'b1;
            wp = (wp + 1) % 8;
            cnt++;
            exp_valid++;
        end
        if (acked && pre > 0) cnt--;
        check_state(tag);
    endtask

    task automatic ack_pulse();
        @(negedge iClk);
        bus.iRxAck = 1'b1;
        @(negedge iClk);
        bus.iRxAck = 1'b0;
        if (cnt > 0) cnt--;
        check("ack count", 32'(bus.oRxCount), 32'(cnt));
    endtask

    task automatic read_chk(input int a, input string tag);
        @(negedge iClk);
        bus.read_addr = 3'(a);
        @(negedge iClk);
        check(tag, 32'(bus.oData), 32'(mem_m[a]));
    endtask

    task automatic do_reset();
        @(negedge iClk);
        iRst = 1'b0;
        iRX = 1'b1;
        tick(2);
        iRst = 1'b1;
        tick(2);
        wp = 0;
        cnt = 0;
    endtask

    initial begin
        bit dummy;
        logic [7:0] b;
        int a;
        bus.read_addr = '0;
        bus.iRxAck = 1'b0;

        // Reset state
        tick(3);
        check("rst rx_addr", 32'(bus.rx_addr), 32'd0);
        check("rst count",   32'(bus.oRxCount), 32'd0);
        check("rst oData",   32'(bus.oData), 32'd0);
        check("rst pulses",  32'({bus.oRxValid, bus.oFrameErr, bus.oOverrun}), 32'd0);
        iRst = 1'b1;
        tick(4);

        // Single frame
        send(8'hA5, 1'b1, 1'b0, "single");
        read_chk(0, "single data");

        // Wrap and full, then overrun leaves mem[0] intact
        do_reset();
        for (int i = 1; i <= 9; i++) send(8'(i), 1'b1, 1'b0, "fill");
        for (int i = 0; i < 8; i++) read_chk(i, "fill data");

        // Framing error, then the same byte good
        do_reset();
        send(8'h3C, 1'b0, 1'b0, "frame err");
        send(8'h3C, 1'b1, 1'b0, "after ferr");
        read_chk(0, "after ferr data");

        // Glitch on the line
        @(negedge iClk);
        iRX = 1'b0;
        tick(2);
        iRX = 1'b1;
        tick(3 * CPB);
        check_state("glitch");
        send(8'h55, 1'b1, 1'b0, "post glitch");
        read_chk(1, "post glitch data");

        // Ack coincident with write at count 3, then drain and ack at 0
        send(8'h77, 1'b1, 1'b0, "to three");
        send(8'h99, 1'b1, 1'b1, "ack+write");
        repeat (4) ack_pulse();
        read_chk(3, "ack+write data");

        // Reset during data bit 4 of 0xFF
        do_reset();
        dummy = 1'b0;
        drive_bit(1'b0, 1'b0, dummy);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b0, dummy);
        tick(CPB / 2);
        iRst = 1'b0;
        iRX = 1'b1;
        tick(3);
        iRst = 1'b1;
        tick(CPB * 2);
        check_state("mid reset");
        send(8'h12, 1'b1, 1'b0, "after reset");
        read_chk(0, "after reset data");

        // Random frames, errors, acks and reads
        for (int n = 0; n < 24; n++) begin
            b = 8'($urandom);
            tick($urandom_range(0, 5));
            send(b, ($urandom_range(0, 5) != 0), ($urandom_range(0, 3) == 0), "rand");
            if ($urandom_range(0, 2) == 0) ack_pulse();
            a = $urandom_range(0, 7);
            if (written[a]) read_chk(a, "rand data");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
